wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage and architectural register file for the 16-bit, 5-stage pipeline. Consumes the MEM/WB latch outputs (op, result data, destination register), commits register writes, and serves the decode stage's two operand reads with same-cycle write bypass. Keeps a pending-write scoreboard that decode sets at issue and writeback clears at commit, and produces an operand-hazard stall. Also keeps a wrapping count of retired instructions.

## Interface
- DATA_W, 16, register/data width
- NREG, 8, number of registers (3-bit indices)
- CLOCK_50  in  1  system clock; all state updates on rising edge
- RESET  in  1  reset, asynchronous, active-high
- OP_IN  in  2  op from MEM/WB latch: 00 NOP, 01 ALU, 10 LOAD, 11 STORE
- DATAIN  in  16  result from MEM/WB latch (ALU result or load data)
- DESTREG_IN  in  3  destination register from MEM/WB latch
- RS1_ADDR, RS2_ADDR  in  3 each  decode read addresses
- RS1_DATA, RS2_DATA  out  16 each  read data (combinational)
- ISSUE_EN  in  1  decode issues an instruction that will write ISSUE_REG
- ISSUE_REG  in  3  destination register of the issuing instruction
- STALL  out  1  decode must hold; a source register has an uncommitted write
- WB_EN  out  1  a register write commits this cycle (combinational)
- WB_REG  out  3  register being written (valid when WB_EN)
- WB_DATA  out  16  data being written (valid when WB_EN)
- RETIRED  out  16  count of retired non-NOP instructions

## Operation
- Write enable: WB_EN = (OP_IN==01 or OP_IN==10) and DESTREG_IN!=0. STORE and NOP never write.
- On a rising edge with WB_EN, regs[DESTREG_IN] <= DATAIN.
- R0 reads as 0 at all times; writes to R0 are dropped; R0 is never marked pending.
- Reads: RSn_DATA = 0 if RSn_ADDR==0; DATAIN if WB_EN and RSn_ADDR==DESTREG_IN (bypass); otherwise regs[RSn_ADDR].
- Scoreboard: pend[7:1], one bit per register.
  - Set: ISSUE_EN and ISSUE_REG!=0 sets pend[ISSUE_REG] at the edge.
  - Clear: WB_EN clears pend[DESTREG_IN] at the edge.
  - Same register set and cleared on the same edge: set wins, because the newer instruction is still outstanding.
- STALL = hazard(RS1_ADDR) or hazard(RS2_ADDR). hazard(r) = r!=0 and pend[r] and not (WB_EN and DESTREG_IN==r). A committing register resolves through the bypass, so it does not stall.
- STALL is advisory. The block still honours ISSUE_EN while STALL is high; decode is responsible for gating it.
- RETIRED increments by 1 on each edge with OP_IN!=00, STORE included. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset (asynchronous, immediate):
  - all regs = 0, pend = 0, RETIRED = 0
  - consequently STALL = 0, and RSn_DATA = 0 unless bypassed
- WB_EN, WB_REG, WB_DATA are combinational from the latch inputs. WB_REG = DESTREG_IN and WB_DATA = DATAIN at all times.
- Write-to-read latency: 0 cycles via bypass in the commit cycle; array value visible from the following cycle.
- Issue-to-stall latency: 1 cycle. pend is set at the edge where ISSUE_EN is sampled; STALL reflects it from the next cycle.
- Reset asserted mid-operation: any pending write is lost and the scoreboard is cleared. After RESET deasserts, the first edge behaves normally.
- Inputs must be stable around the CLOCK_50 rising edge. No other handshake exists.

## Test plan
- Reset release: assert RESET, then drop it. Required: RS1_DATA=RS2_DATA=0, STALL=0, RETIRED=0. Read every register → all 0.
- ALU writeback plus bypass: OP_IN=01, DESTREG_IN=3, DATAIN=0x1234, RS1_ADDR=3.
  - Same cycle: RS1_DATA=0x1234, WB_EN=1.
  - Next cycle with OP_IN=00: RS1_DATA=0x1234.
- R0 and STORE: OP_IN=10, DESTREG_IN=0, DATAIN=0xBEEF → WB_EN=0, R0 reads 0. OP_IN=11, DESTREG_IN=5, DATAIN=0x5555 → R5 unchanged. RETIRED +2.
- Scoreboard:
  - ISSUE_EN=1, ISSUE_REG=4; next cycle RS2_ADDR=4 → STALL=1.
  - Commit cycle (OP_IN=01, DESTREG_IN=4, DATAIN=0x00AA) → STALL=0 and RS2_DATA=0x00AA.
  - Afterwards STALL stays 0.
- Simultaneous set/clear: pend[2]=1; on the same edge, commit to R2 and ISSUE_EN with ISSUE_REG=2. Required: pend[2] remains 1; next cycle RS1_ADDR=2 → STALL=1.
- Counter wrap and async reset:
  - Drive 65536 non-NOP ops → RETIRED wraps to 0x0000.
  - Then 3 ALU ops, then pulse RESET between edges → RETIRED=0 immediately and all pend bits clear.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: MEM/WB latch inputs, decode read/issue ports, commit and status outputs.
interface wb_stage_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned AW     = 3;

  logic [1:0]        OP_IN;
  logic [DATA_W-1:0] DATAIN;
  logic [AW-1:0]     DESTREG_IN;
  logic [AW-1:0]     RS1_ADDR;
  logic [AW-1:0]     RS2_ADDR;
  logic [DATA_W-1:0] RS1_DATA;
  logic [DATA_W-1:0] RS2_DATA;
  logic              ISSUE_EN;
  logic [AW-1:0]     ISSUE_REG;
  logic              STALL;
  logic              WB_EN;
  logic [AW-1:0]     WB_REG;
  logic [DATA_W-1:0] WB_DATA;
  logic [DATA_W-1:0] RETIRED;

  // Pipeline / decode side driving the stage
  modport master (
    output OP_IN, DATAIN, DESTREG_IN, RS1_ADDR, RS2_ADDR, ISSUE_EN, ISSUE_REG,
    input  RS1_DATA, RS2_DATA, STALL, WB_EN, WB_REG, WB_DATA, RETIRED
  );

  // The writeback stage itself
  modport slave (
    input  OP_IN, DATAIN, DESTREG_IN, RS1_ADDR, RS2_ADDR, ISSUE_EN, ISSUE_REG,
    output RS1_DATA, RS2_DATA, STALL, WB_EN, WB_REG, WB_DATA, RETIRED
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: register file with commit bypass, pending-write scoreboard,
// operand-hazard stall and retired-instruction counter.
module wb_stage (
  input  logic      CLOCK_50,
  input  logic      RESET,
  wb_stage_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned AW     = 3;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;
  logic [NREG-1:0]   clr_mask;
  logic [NREG-1:0]   set_mask;
  logic [DATA_W-1:0] retired;
  logic              wb_en;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              hz1;
  logic              hz2;

  // Only ALU and LOAD with a non-zero destination commit a write
  assign wb_en = ((bus.OP_IN == 2'b01) || (bus.OP_IN == 2'b10)) && (bus.DESTREG_IN != AW'(0));

  // Scoreboard next state: clear the committing register, then set the issuing one so set wins
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_en) clr_mask[bus.DESTREG_IN] = 1'b1;
    if (bus.ISSUE_EN && (bus.ISSUE_REG != AW'(0))) set_mask[bus.ISSUE_REG] = 1'b1;
    pend_nxt = (pend & ~clr_mask) | set_mask;
  end

  // Operand reads: R0 is zero, a committing register is bypassed from the latch
  always_comb begin
    rs1_data = regs[bus.RS1_ADDR];
    rs2_data = regs[bus.RS2_ADDR];
    if (wb_en && (bus.RS1_ADDR == bus.DESTREG_IN)) rs1_data = bus.DATAIN;
    if (wb_en && (bus.RS2_ADDR == bus.DESTREG_IN)) rs2_data = bus.DATAIN;
    if (bus.RS1_ADDR == AW'(0)) rs1_data = '0;
    if (bus.RS2_ADDR == AW'(0)) rs2_data = '0;
  end

  // Hazard: source pending and not being resolved by this cycle's commit
  always_comb begin
    hz1 = (bus.RS1_ADDR != AW'(0)) && pend[bus.RS1_ADDR] &&
          !(wb_en && (bus.DESTREG_IN == bus.RS1_ADDR));
    hz2 = (bus.RS2_ADDR != AW'(0)) && pend[bus.RS2_ADDR] &&
          !(wb_en && (bus.DESTREG_IN == bus.RS2_ADDR));
  end

  // Register file, scoreboard and retire counter
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      pend    <= '0;
      retired <= '0;
    end else begin
      if (wb_en) regs[bus.DESTREG_IN] <= bus.DATAIN;
      pend <= pend_nxt;
      if (bus.OP_IN != 2'b00) retired <= retired + DATA_W'(1);
    end
  end

  assign bus.RS1_DATA = rs1_data;
  assign bus.RS2_DATA = rs2_data;
  assign bus.STALL    = hz1 || hz2;
  assign bus.WB_EN    = wb_en;
  assign bus.WB_REG   = bus.DESTREG_IN;
  assign bus.WB_DATA  = bus.DATAIN;
  assign bus.RETIRED  = retired;
endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_stage;
  logic CLOCK_50;
  logic RESET;
  int   n_checks;
  int   n_fail;

  wb_stage_if bus ();

  wb_stage dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Behavioural model of architectural state
  logic [15:0] mregs [8];
  bit          mpend [8];
  logic [15:0] mret;

  function automatic bit m_writes();
    return ((bus.OP_IN == 2'd1) || (bus.OP_IN == 2'd2)) && (bus.DESTREG_IN != 3'd0);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (m_writes() && (a == bus.DESTREG_IN)) return bus.DATAIN;
    return mregs[a];
  endfunction

  function automatic bit m_hazard(input logic [2:0] a);
    return (a != 3'd0) && mpend[a] && !(m_writes() && (bus.DESTREG_IN == a));
  endfunction

  function automatic bit m_stall();
    return m_hazard(bus.RS1_ADDR) || m_hazard(bus.RS2_ADDR);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mregs[i] = 16'h0000;
      mpend[i] = 1'b0;
    end
    mret = 16'h0000;
  endtask

  // Drive one cycle's inputs at the falling edge, settle before checking
  task automatic drive(input logic [1:0] op, input logic [15:0] d, input logic [2:0] dst,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic ie, input logic [2:0] ir);
    @(negedge CLOCK_50);
    bus.OP_IN      = op;
    bus.DATAIN     = d;
    bus.DESTREG_IN = dst;
    bus.RS1_ADDR   = a1;
    bus.RS2_ADDR   = a2;
    bus.ISSUE_EN   = ie;
    bus.ISSUE_REG  = ir;
    #1;
  endtask

  // Advance one rising edge and apply the same edge to the model
  task automatic tick();
    bit wr;
    @(posedge CLOCK_50);
    wr = m_writes();
    if (wr) begin
      mregs[bus.DESTREG_IN] = bus.DATAIN;
      mpend[bus.DESTREG_IN] = 1'b0;
    end
    if (bus.ISSUE_EN && (bus.ISSUE_REG != 3'd0)) mpend[bus.ISSUE_REG] = 1'b1;
    if (bus.OP_IN != 2'd0) mret = mret + 16'd1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    model_reset();
    drive(2'd0, 16'h0, 3'd0, 3'd1, 3'd2, 1'b0, 3'd0);
    n_checks++;
    if (bus.RETIRED !== 16'h0000) begin
      n_fail++; $display("FAIL reset_retired: got %h expected 0000", bus.RETIRED);
    end
    n_checks++;
    if (bus.STALL !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.STALL);
    end
    @(negedge CLOCK_50);
    RESET = 1'b0;
    for (int r = 0; r < 8; r++) begin
      drive(2'd0, 16'h0, 3'd0, 3'(r), 3'(7 - r), 1'b0, 3'd0);
      n_checks++;
      if (bus.RS1_DATA !== 16'h0000) begin
        n_fail++; $display("FAIL reset_rs1_r%0d: got %h expected 0000", r, bus.RS1_DATA);
      end
      n_checks++;
      if (bus.RS2_DATA !== 16'h0000) begin
        n_fail++; $display("FAIL reset_rs2_r%0d: got %h expected 0000", 7 - r, bus.RS2_DATA);
      end
      tick();
    end
  endtask

  task automatic test_alu_bypass();
    drive(2'd1, 16'h1234, 3'd3, 3'd3, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if (bus.RS1_DATA !== 16'h1234) begin
      n_fail++; $display("FAIL bypass_rs1: got %h expected 1234", bus.RS1_DATA);
    end
    n_checks++;
    if ({bus.WB_EN, bus.WB_REG, bus.WB_DATA} !== {1'b1, 3'd3, 16'h1234}) begin
      n_fail++; $display("FAIL bypass_wb: got %b/%0d/%h expected 1/3/1234", bus.WB_EN, bus.WB_REG, bus.WB_DATA);
    end
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd3, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if (bus.RS1_DATA !== 16'h1234) begin
      n_fail++; $display("FAIL array_rs1: got %h expected 1234", bus.RS1_DATA);
    end
    tick();
  endtask

  task automatic test_r0_store();
    logic [15:0] r_before;
    logic [15:0] r5_before;
    r_before  = mret;
    r5_before = mregs[5];
    drive(2'd2, 16'hBEEF, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if ({bus.WB_EN, bus.RS1_DATA} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL r0_load: got wb_en=%b rs1=%h expected 0/0000", bus.WB_EN, bus.RS1_DATA);
    end
    tick();
    drive(2'd3, 16'h5555, 3'd5, 3'd5, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if ({bus.WB_EN, bus.RS1_DATA} !== {1'b0, r5_before}) begin
      n_fail++; $display("FAIL store_nowrite: got wb_en=%b rs1=%h expected 0/%h", bus.WB_EN, bus.RS1_DATA, r5_before);
    end
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd5, 1'b0, 3'd0);
    n_checks++;
    if (bus.RS2_DATA !== r5_before) begin
      n_fail++; $display("FAIL store_r5: got %h expected %h", bus.RS2_DATA, r5_before);
    end
    n_checks++;
    if (bus.RETIRED !== r_before + 16'd2) begin
      n_fail++; $display("FAIL retired_plus2: got %h expected %h", bus.RETIRED, r_before + 16'd2);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd4, 1'b1, 3'd4);
    n_checks++;
    if (bus.STALL !== 1'b0) begin
      n_fail++; $display("FAIL sb_issue_cycle: got %b expected 0", bus.STALL);
    end
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0);
    n_checks++;
    if (bus.STALL !== 1'b1) begin
      n_fail++; $display("FAIL sb_stall: got %b expected 1", bus.STALL);
    end
    tick();
    drive(2'd1, 16'h00AA, 3'd4, 3'd0, 3'd4, 1'b0, 3'd0);
    n_checks++;
    if ({bus.STALL, bus.RS2_DATA} !== {1'b0, 16'h00AA}) begin
      n_fail++; $display("FAIL sb_commit: got stall=%b rs2=%h expected 0/00aa", bus.STALL, bus.RS2_DATA);
    end
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd4, 3'd4, 1'b0, 3'd0);
    n_checks++;
    if ({bus.STALL, bus.RS1_DATA} !== {1'b0, 16'h00AA}) begin
      n_fail++; $display("FAIL sb_after: got stall=%b rs1=%h expected 0/00aa", bus.STALL, bus.RS1_DATA);
    end
    tick();
  endtask

  task automatic test_set_clear();
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd2);
    tick();
    drive(2'd1, 16'h7777, 3'd2, 3'd0, 3'd0, 1'b1, 3'd2);
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd2, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if ({bus.STALL, bus.RS1_DATA} !== {1'b1, 16'h7777}) begin
      n_fail++; $display("FAIL set_wins: got stall=%b rs1=%h expected 1/7777", bus.STALL, bus.RS1_DATA);
    end
    tick();
    drive(2'd1, 16'h0002, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0);
    tick();
  endtask

  task automatic test_random();
    logic [15:0] e1, e2;
    bit          es, ew;
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 16'($urandom), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      e1 = m_read(bus.RS1_ADDR);
      e2 = m_read(bus.RS2_ADDR);
      es = m_stall();
      ew = m_writes();
      n_checks++;
      if (bus.RS1_DATA !== e1) begin
        n_fail++; $display("FAIL rnd_rs1 #%0d: got %h expected %h", i, bus.RS1_DATA, e1);
      end
      n_checks++;
      if (bus.RS2_DATA !== e2) begin
        n_fail++; $display("FAIL rnd_rs2 #%0d: got %h expected %h", i, bus.RS2_DATA, e2);
      end
      n_checks++;
      if (bus.STALL !== es) begin
        n_fail++; $display("FAIL rnd_stall #%0d: got %b expected %b", i, bus.STALL, es);
      end
      n_checks++;
      if ({bus.WB_EN, bus.WB_REG, bus.WB_DATA} !== {ew, bus.DESTREG_IN, bus.DATAIN}) begin
        n_fail++; $display("FAIL rnd_wb #%0d: got %b/%0d/%h expected %b/%0d/%h", i,
                           bus.WB_EN, bus.WB_REG, bus.WB_DATA, ew, bus.DESTREG_IN, bus.DATAIN);
      end
      n_checks++;
      if (bus.RETIRED !== mret) begin
        n_fail++; $display("FAIL rnd_retired #%0d: got %h expected %h", i, bus.RETIRED, mret);
      end
      tick();
    end
  endtask

  task automatic test_wrap_and_reset();
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(2'($urandom_range(1, 3)), 16'($urandom), 3'($urandom_range(0, 7)), 3'd0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if (bus.RETIRED !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max: got %h expected ffff", bus.RETIRED);
    end
    tick();
    drive(2'd3, 16'h0, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    n_checks++;
    if (bus.RETIRED !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got %h expected 0000", bus.RETIRED);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'd1, 16'($urandom), 3'd1, 3'd0, 3'd0, 1'b1, 3'(5 + k));
      tick();
    end
    drive(2'd0, 16'h0, 3'd0, 3'd5, 3'd6, 1'b0, 3'd0);
    n_checks++;
    if ({bus.STALL, bus.RETIRED} !== {1'b1, 16'd3}) begin
      n_fail++; $display("FAIL pre_reset: got stall=%b retired=%h expected 1/0003", bus.STALL, bus.RETIRED);
    end
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({bus.STALL, bus.RETIRED, bus.RS1_DATA} !== {1'b0, 16'h0000, 16'h0000}) begin
      n_fail++; $display("FAIL async_reset: got stall=%b retired=%h rs1=%h expected 0/0000/0000",
                         bus.STALL, bus.RETIRED, bus.RS1_DATA);
    end
    bus.RS1_ADDR = 3'd7;
    #1;
    n_checks++;
    if (bus.STALL !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_r7: got %b expected 0", bus.STALL);
    end
    RESET = 1'b0;
    model_reset();
    drive(2'd1, 16'h0F0F, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(2'd0, 16'h0, 3'd0, 3'd5, 3'd1, 1'b0, 3'd0);
    n_checks++;
    if ({bus.RS1_DATA, bus.RS2_DATA, bus.RETIRED} !== {16'h0F0F, 16'h0000, 16'h0001}) begin
      n_fail++; $display("FAIL post_reset: got rs1=%h rs2=%h retired=%h expected 0f0f/0000/0001",
                         bus.RS1_DATA, bus.RS2_DATA, bus.RETIRED);
    end
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    RESET          = 1'b1;
    bus.OP_IN      = 2'd0;
    bus.DATAIN     = 16'h0;
    bus.DESTREG_IN = 3'd0;
    bus.RS1_ADDR   = 3'd0;
    bus.RS2_ADDR   = 3'd0;
    bus.ISSUE_EN   = 1'b0;
    bus.ISSUE_REG  = 3'd0;
    test_reset();
    test_alu_bypass();
    test_r0_store();
    test_scoreboard();
    test_set_clear();
    test_random();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
